regfile_scoreboard: RTL
=======================

# regfile_scoreboard

RV32E integer register file with an integrated pending-write scoreboard. It is the consumer of the WB stage outputs: it commits writeback results, supplies the two decode-stage read operands, and bypasses same-cycle writes. It also tracks in-flight writes per register so that decode can stall on RAW hazards. It sits between the decode stage (reads, issue reservations) and the MEMEX→WB pipeline register (writes, releases).

## Interface
- PENDING_W, 2, width of each per-register pending-write counter; max count = 2^PENDING_W − 1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- rs1_addr  input  4  read port 1 register index
- rs2_addr  input  4  read port 2 register index
- rs1_data  output  32 (integer)  read port 1 data
- rs2_data  output  32 (integer)  read port 2 data
- rs1_busy  output  1  rs1 has an outstanding write
- rs2_busy  output  1  rs2 has an outstanding write
- issue_valid  input  1  decode issues an instruction that will write issue_rd
- issue_rd  input  4  destination being reserved
- issue_ready  output  1  reservation is accepted this cycle
- rd_WB  input  4  writeback destination
- alu_result_WB  input  32 (integer)  writeback data
- regfile_we_WB  input  1  commit alu_result_WB to rd_WB
- release_WB  input  1  a reserving instruction reached WB; asserted even if it was invalidated (we forced 0)
- scoreboard_err  output  1  sticky underflow flag

## Operation
- Storage: x1–x15 are 32-bit registers. x0 is not stored; it reads 0, is never busy, and writes to it are dropped.
- Write: on posedge, if regfile_we_WB and rd_WB≠0, then regs[rd_WB] ← alu_result_WB.
- Read (combinational), per port:
  - rs==0 → 0.
  - Otherwise, regfile_we_WB && rd_WB==rs → alu_result_WB (write-through bypass).
  - Otherwise → regs[rs].
- Pending counters pend[1..15], each PENDING_W bits. Per posedge:
  - inc = issue_valid && issue_ready && issue_rd≠0 (targets issue_rd).
  - dec = release_WB && rd_WB≠0 (targets rd_WB).
  - Same register, inc and dec together: no change.
  - dec when pend==0: counter stays 0 and scoreboard_err ← 1. The flag is sticky until reset.
- busy (combinational), per port: rs≠0 and (pend[rs] − (dec && rd_WB==rs)) ≠ 0. A release landing this cycle is seen as already retired, consistent with the data bypass.
- issue_ready = 0 only when issue_rd≠0, pend[issue_rd] == max, and there is no same-cycle dec to issue_rd. Otherwise it is 1.
  - issue_rd==0 is always ready and has no effect.
  - issue_valid with issue_ready=0 is ignored; decode must hold and retry.
- release_WB and regfile_we_WB are independent:
  - we=1 with release=0 writes data and leaves the counter unchanged.
  - release=1 with we=0 frees the reservation without a write.

## Timing
- Reads, busy and issue_ready are zero-latency combinational.
- A write performed at edge N is visible from stored state after edge N. In cycle N it is visible through the bypass.
- A counter update at edge N is reflected in busy and issue_ready after edge N, except for the same-cycle dec lookahead.
- Reset (rst_n=0, asynchronous):
  - All regs clear to 0, all pend clear to 0, scoreboard_err = 0.
  - While reset is held, writes and counter updates are blocked, and outputs are forced: rs*_data=0, rs*_busy=0, issue_ready=0.
- Reset asserted mid-operation discards all reservations. Releases after reset for instructions issued before reset set scoreboard_err. The pipeline must therefore be reset together with this block.
- Saturation: with PENDING_W=2, a 4th concurrent reservation of one register stalls until a release.

## Test plan
- Reset, then read all 16 indices → all 0, busy=0, scoreboard_err=0, issue_ready=1 after rst_n rises.
- Write x5=0xDEADBEEF (we=1) with rs1_addr=5 in the same cycle → rs1_data=0xDEADBEEF combinationally. Next cycle with we=0 → still 0xDEADBEEF. Write x0=0x1234 → x0 reads 0.
- Issue rd=7 → rs2_addr=7 busy=1 next cycle. Release rd=7 with we=1, data=0x42 → that cycle busy=0 and rs2_data=0x42. After the edge, pend[7]=0.
- Issue rd=3 three times → issue_ready=0 on the 4th attempt (pend stays 3). Same cycle with release rd=3 → ready=1, pend stays 3.
- Release rd=9 with pend[9]=0 → scoreboard_err=1 and stays 1. Release with we=0 on reserved x4 → pend decrements and x4 data is unchanged.
- Assert rst_n=0 asynchronously mid-cycle with pend[2]=2 and x2=0x55 → outputs go 0 immediately. After release, x2=0 and busy=0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// RV32E integer register file (x1-x15) with write-through bypass and a
// per-register pending-write scoreboard used by decode for RAW stalls.
module regfile_scoreboard #(
  parameter int PENDING_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rs1_addr,
  input  logic [3:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        rs1_busy,
  output logic        rs2_busy,
  input  logic        issue_valid,
  input  logic [3:0]  issue_rd,
  output logic        issue_ready,
  input  logic [3:0]  rd_WB,
  input  logic [31:0] alu_result_WB,
  input  logic        regfile_we_WB,
  input  logic        release_WB,
  output logic        scoreboard_err
);

  localparam logic [PENDING_W-1:0] PEND_MAX = '1;

  // Entry 0 exists only so 4-bit indices never leave the array; it is never written.
  logic [31:0]          regs [16];
  logic [PENDING_W-1:0] pend [16];
  logic                 inc;
  logic                 dec;
  logic                 underflow;

  function automatic logic [31:0] read_data(input logic [3:0] rs);
    if (rs == '0)
      return '0;
    else if (regfile_we_WB && rd_WB == rs)
      return alu_result_WB;
    else
      return regs[rs];
  endfunction

  // A release landing this cycle already counts as retired.
  function automatic logic read_busy(input logic [3:0] rs);
    logic [PENDING_W-1:0] eff;
    eff = pend[rs] - PENDING_W'(dec && rd_WB == rs);
    return (rs != '0) && (eff != '0);
  endfunction

  assign dec = release_WB && (rd_WB != '0);
  assign inc = issue_valid && issue_ready && (issue_rd != '0);
  assign underflow = dec && (pend[rd_WB] == '0) && !(inc && issue_rd == rd_WB);

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    issue_ready = 1'b0;
    rs1_data    = '0;
    rs2_data    = '0;
    rs1_busy    = 1'b0;
    rs2_busy    = 1'b0;
    if (rst_n) begin
      issue_ready = !((issue_rd != '0) && (pend[issue_rd] == PEND_MAX) &&
                      !(dec && rd_WB == issue_rd));
      rs1_data    = read_data(rs1_addr);
      rs2_data    = read_data(rs2_addr);
      rs1_busy    = read_busy(rs1_addr);
      rs2_busy    = read_busy(rs2_addr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage array is reset because registers must read 0 after reset.
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (regfile_we_WB && rd_WB != '0) begin
      // NOTE: non-blocking assignment for all sequential state.
      regs[rd_WB] <= alu_result_WB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (inc && issue_rd == 4'(i) && !(dec && rd_WB == 4'(i)))
          pend[i] <= pend[i] + PENDING_W'(1);
        else if (dec && rd_WB == 4'(i) && !(inc && issue_rd == 4'(i)) && pend[i] != '0)
          pend[i] <= pend[i] - PENDING_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      scoreboard_err <= 1'b0;
    else if (underflow)
      scoreboard_err <= 1'b1;
  end

endmodule
